// File: rtl/maxnet_pkg.sv
// Shared definitions for the MAXNET convergence monitor: default sizing,
// state encoding and the lane slicing helper.
package maxnet_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_ITER = 255;
  localparam int DEF_IW       = $clog2(DEF_MAX_ITER + 1);
  localparam int DEF_IDXW     = $clog2(DEF_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Low bit of lane i in a flat vector of dw-bit lanes.
  function automatic int lane_lo(input int i, input int dw);
    return i * dw;
  endfunction

endpackage

// File: rtl/maxnet_convergence_monitor_positive_scan.sv
// Combinational scan of the activation vector: counts strictly positive
// lanes and reports the lowest-index positive lane.
module positive_scan
  import maxnet_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int DW   = DEF_DW,
  localparam int CW   = $clog2(N + 1),
  localparam int IDXW = $clog2(N)
) (
  input  logic [N*DW-1:0] vec,
  output logic [CW-1:0]   pos_cnt,
  output logic [IDXW-1:0] first_idx
);

  // Positive means sign bit clear and not zero.
  always_comb begin
    logic [DW-1:0] lane;
    logic          found;
    pos_cnt   = '0;
    first_idx = '0;
    found     = 1'b0;
    lane      = '0;
    for (int i = 0; i < N; i++) begin
      lane = vec[lane_lo(i, DW) +: DW];
      if (!lane[DW-1] && (|lane)) begin
        pos_cnt = pos_cnt + CW'(1);
        if (!found) begin
          first_idx = IDXW'(i);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/maxnet_convergence_monitor.sv
// Responder to the neuron-array sequencer: holds the x feedback vector,
// captures activations, counts iterations, raises done on convergence or
// iteration limit, and hands the winner out over a valid/ready port.
module maxnet_convergence_monitor
  import maxnet_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int DW       = DEF_DW,
  parameter int MAX_ITER = DEF_MAX_ITER,
  localparam int IW   = $clog2(MAX_ITER + 1),
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_mux,
  input  logic            en_a,
  input  logic            en_x,
  input  logic [N*DW-1:0] x_init,
  input  logic [N*DW-1:0] act_in,
  output logic [N*DW-1:0] x_out,
  output logic            done,
  output logic [IW-1:0]   iter_count,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IDXW-1:0] winner_idx,
  output logic [DW-1:0]   winner_val,
  output logic            winner_none,
  output logic            timeout
);

  localparam int CW = $clog2(N + 1);

  state_e            state_q, state_d;
  logic [N*DW-1:0]   x_q, x_d, a_q, a_d;
  logic              a_valid_q, a_valid_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic              res_valid_q, res_valid_d;
  logic [IDXW-1:0]   win_idx_q, win_idx_d;
  logic [DW-1:0]     win_val_q, win_val_d;
  logic              win_none_q, win_none_d;
  logic              timeout_q, timeout_d;

  logic [CW-1:0]     pos_cnt;
  logic [IDXW-1:0]   first_idx;
  logic              at_limit;

  positive_scan #(.N(N), .DW(DW)) u_scan (
    .vec       (a_q),
    .pos_cnt   (pos_cnt),
    .first_idx (first_idx)
  );

  // The write about to happen would be the MAX_ITER-th one.
  assign at_limit = ({1'b0, iter_q} + (IW+1)'(1)) >= (IW+1)'(MAX_ITER);
  assign done     = (state_q == RUN) && a_valid_q && ((pos_cnt <= CW'(1)) || at_limit);

  // Next-state and datapath updates; init_mux overrides everything else.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    a_d         = a_q;
    a_valid_d   = a_valid_q;
    iter_d      = iter_q;
    res_valid_d = res_valid_q;
    win_idx_d   = win_idx_q;
    win_val_d   = win_val_q;
    win_none_d  = win_none_q;
    timeout_d   = timeout_q;
    if (init_mux) begin
      state_d     = RUN;
      x_d         = x_init;
      iter_d      = '0;
      a_valid_d   = 1'b0;
      res_valid_d = 1'b0;
      win_idx_d   = '0;
      win_val_d   = '0;
      win_none_d  = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (en_a) begin
            a_d       = act_in;
            a_valid_d = 1'b1;
          end
          if (en_x && a_valid_q) begin
            x_d = a_q;
            if (iter_q != IW'(MAX_ITER)) iter_d = iter_q + IW'(1);
            if (done) begin
              state_d     = REPORT;
              res_valid_d = 1'b1;
              win_idx_d   = first_idx;
              win_val_d   = (pos_cnt == '0) ? '0 : a_q[lane_lo(int'(first_idx), DW) +: DW];
              win_none_d  = (pos_cnt == '0);
              timeout_d   = (pos_cnt > CW'(1));
            end
          end
        end
        REPORT: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      a_q         <= '0;
      a_valid_q   <= 1'b0;
      iter_q      <= '0;
      res_valid_q <= 1'b0;
      win_idx_q   <= '0;
      win_val_q   <= '0;
      win_none_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      a_q         <= a_d;
      a_valid_q   <= a_valid_d;
      iter_q      <= iter_d;
      res_valid_q <= res_valid_d;
      win_idx_q   <= win_idx_d;
      win_val_q   <= win_val_d;
      win_none_q  <= win_none_d;
      timeout_q   <= timeout_d;
    end
  end

  assign x_out       = x_q;
  assign iter_count  = iter_q;
  assign res_valid   = res_valid_q;
  assign winner_idx  = win_idx_q;
  assign winner_val  = win_val_q;
  assign winner_none = win_none_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_maxnet_convergence_monitor.sv
// Directed bench: two monitor instances (default limit and MAX_ITER=3),
// expected results queued by the stimulus, popped by a handshake monitor.
module tb_maxnet_convergence_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_mux = 1'b0, en_a = 1'b0, en_x = 1'b0, res_ready = 1'b1, sel_b = 1'b0;
  logic [31:0] x_init = '0, act_in = '0;

  always #5 clk = ~clk;

  typedef struct {
    int idx; int val; logic none; logic tmo; int iter;
  } exp_t;
  exp_t qa[$], qb[$];

  int tests = 0, fails = 0;

  // DUT A: default limit
  logic [31:0] xa;
  logic        done_a, rv_a, wn_a, to_a;
  logic [7:0]  it_a, wv_a;
  logic [1:0]  wi_a;
  maxnet_convergence_monitor dut_a (
    .clk(clk), .rst(rst), .init_mux(init_mux & ~sel_b), .en_a(en_a & ~sel_b),
    .en_x(en_x & ~sel_b), .x_init(x_init), .act_in(act_in), .x_out(xa), .done(done_a),
    .iter_count(it_a), .res_valid(rv_a), .res_ready(res_ready), .winner_idx(wi_a),
    .winner_val(wv_a), .winner_none(wn_a), .timeout(to_a));

  // DUT B: MAX_ITER = 3
  logic [31:0] xb;
  logic        done_b, rv_b, wn_b, to_b;
  logic [1:0]  it_b, wi_b;
  logic [7:0]  wv_b;
  maxnet_convergence_monitor #(.MAX_ITER(3)) dut_b (
    .clk(clk), .rst(rst), .init_mux(init_mux & sel_b), .en_a(en_a & sel_b),
    .en_x(en_x & sel_b), .x_init(x_init), .act_in(act_in), .x_out(xb), .done(done_b),
    .iter_count(it_b), .res_valid(rv_b), .res_ready(res_ready), .winner_idx(wi_b),
    .winner_val(wv_b), .winner_none(wn_b), .timeout(to_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    logic [31:0] v;
    v = {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_init(input logic [31:0] x);
    init_mux = 1'b1; x_init = x;
    tick();
    init_mux = 1'b0;
  endtask

  // One capture + write-back; done is checked while en_x is presented.
  task automatic do_iter(input string nm, input logic [31:0] act, input logic exp_done);
    en_a = 1'b1; act_in = act;
    tick();
    en_a = 1'b0; en_x = 1'b1;
    chk(nm, sel_b ? done_b : done_a, exp_done);
    tick();
    en_x = 1'b0;
  endtask

  // Result monitor: compare whenever a handshake is about to complete.
  always @(negedge clk) begin
    exp_t e;
    if (rv_a && res_ready) begin
      if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_idx", wi_a, e.idx); chk("a_val", wv_a, e.val);
        chk("a_none", wn_a, e.none); chk("a_tmo", to_a, e.tmo); chk("a_iter", it_a, e.iter);
      end
    end
    if (rv_b && res_ready) begin
      if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_idx", wi_b, e.idx); chk("b_val", wv_b, e.val);
        chk("b_none", wn_b, e.none); chk("b_tmo", to_b, e.tmo); chk("b_iter", it_b, e.iter);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("rst_x", xa, 0); chk("rst_iter", it_a, 0); chk("rst_done", done_a, 0);
    chk("rst_rv", rv_a, 0); chk("rst_widx", wi_a, 0); chk("rst_wval", wv_a, 0);
    chk("rst_rv_b", rv_b, 0);
    rst = 1'b0;
    tick();

    // 1: converges on third write
    do_init(pk(10, 20, 30, 40));
    chk("t1_xinit", xa, pk(10, 20, 30, 40)); chk("t1_iter0", it_a, 0);
    do_iter("t1_done1", pk(0, 5, 15, 25), 0);
    chk("t1_x1", xa, pk(0, 5, 15, 25)); chk("t1_iter1", it_a, 1);
    do_iter("t1_done2", pk(0, 0, 4, 14), 0);
    qa.push_back('{idx: 3, val: 8, none: 0, tmo: 0, iter: 3});
    do_iter("t1_done3", pk(0, 0, 0, 8), 1);
    chk("t1_rv", rv_a, 1); chk("t1_x3", xa, pk(0, 0, 0, 8));
    tick();
    chk("t1_rv_drop", rv_a, 0);

    // 2: nothing positive on first write
    do_init(pk(1, 2, 3, 4));
    qa.push_back('{idx: 0, val: 0, none: 1, tmo: 0, iter: 1});
    do_iter("t2_done", pk(0, -3, 0, -128), 1);
    tick();
    chk("t2_rv_drop", rv_a, 0);

    // 4: consumer stalls for 10 cycles
    res_ready = 1'b0;
    do_init(pk(3, 3, 3, 3));
    qa.push_back('{idx: 2, val: 7, none: 0, tmo: 0, iter: 1});
    do_iter("t4_done", pk(0, 0, 7, 0), 1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_rv", rv_a, 1); chk("t4_stall_idx", wi_a, 2); chk("t4_stall_val", wv_a, 7);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("t4_rv_drop", rv_a, 0);
    // back in IDLE: strobes are ignored
    do_iter("t4_idle_done", pk(9, 9, 9, 9), 0);
    chk("t4_idle_x", xa, pk(0, 0, 7, 0)); chk("t4_idle_iter", it_a, 1);

    // 5a: restart while reporting
    res_ready = 1'b0;
    do_init(pk(9, 9, 9, 9));
    do_iter("t5_done", pk(0, 0, 0, 1), 1);
    chk("t5_rv", rv_a, 1);
    do_init(pk(11, 12, 13, 14));
    chk("t5a_x", xa, pk(11, 12, 13, 14)); chk("t5a_iter", it_a, 0); chk("t5a_rv", rv_a, 0);
    res_ready = 1'b1;
    // 5b: restart in the same cycle as a write
    do_iter("t5b_done1", pk(0, 5, 15, 25), 0);
    chk("t5b_iter1", it_a, 1);
    en_a = 1'b1; act_in = pk(0, 0, 0, 3);
    tick();
    en_a = 1'b0; en_x = 1'b1; init_mux = 1'b1; x_init = pk(21, 22, 23, 24);
    tick();
    en_x = 1'b0; init_mux = 1'b0;
    chk("t5b_x", xa, pk(21, 22, 23, 24)); chk("t5b_iter", it_a, 0); chk("t5b_rv", rv_a, 0);
    // en_x without a fresh capture is ignored
    en_x = 1'b1;
    chk("t5b_nodone", done_a, 0);
    tick();
    en_x = 1'b0;
    chk("t5b_nowrite_x", xa, pk(21, 22, 23, 24)); chk("t5b_nowrite_iter", it_a, 0);

    // 3: tie never converges, limit of 3 forces timeout
    sel_b = 1'b1;
    do_init(pk(1, 1, 1, 1));
    do_iter("t3_done1", pk(5, 5, 0, 0), 0);
    do_iter("t3_done2", pk(5, 5, 0, 0), 0);
    qb.push_back('{idx: 0, val: 5, none: 0, tmo: 1, iter: 3});
    do_iter("t3_done3", pk(5, 5, 0, 0), 1);
    chk("t3_rv", rv_b, 1);
    tick();
    chk("t3_rv_drop", rv_b, 0);
    sel_b = 1'b0;

    // 6: asynchronous reset mid-run
    do_init(pk(10, 20, 30, 40));
    do_iter("t6_done1", pk(0, 5, 15, 25), 0);
    en_a = 1'b1; act_in = pk(0, 0, 0, 3);
    tick();
    en_a = 1'b0;
    chk("t6_pre_done", done_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_x", xa, 0); chk("t6_iter", it_a, 0); chk("t6_done", done_a, 0);
    chk("t6_rv", rv_a, 0); chk("t6_wval", wv_a, 0);
    tick();
    rst = 1'b0;
    tick(); tick();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
